// File: rtl/window_reader_pkg.sv
// Shared types and constants for the 3x3 window reader.
// Holds the FSM state enum, the neighbour fetch-order indices P1..P9
// and the neighbour count.
package window_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned NBR_CNT = 9;
  localparam int unsigned IDX_W   = 4;

  // Fetch order: centre, then clockwise starting at north.
  localparam logic [IDX_W-1:0] P1 = 4'd0;  // centre
  localparam logic [IDX_W-1:0] P2 = 4'd1;  // N
  localparam logic [IDX_W-1:0] P3 = 4'd2;  // NE
  localparam logic [IDX_W-1:0] P4 = 4'd3;  // E
  localparam logic [IDX_W-1:0] P5 = 4'd4;  // SE
  localparam logic [IDX_W-1:0] P6 = 4'd5;  // S
  localparam logic [IDX_W-1:0] P7 = 4'd6;  // SW
  localparam logic [IDX_W-1:0] P8 = 4'd7;  // W
  localparam logic [IDX_W-1:0] P9 = 4'd8;  // NW

endpackage

// File: rtl/window_addr_gen.sv
// Neighbour address generator.
// Maps a centre linear address and a fetch index (P1..P9) to the RAM
// address of that neighbour using only adds/subtracts of N.
//   i_center_addr : linear address of the window centre
//   i_idx         : neighbour index
//   o_addr_c      : combinational neighbour address (wraps modulo 2^(bitSize+1))
module window_addr_gen
  import window_reader_pkg::*;
#(
  parameter int N       = 8,
  parameter int bitSize = 6
) (
  input  logic [bitSize:0]  i_center_addr,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [bitSize:0]  o_addr_c
);

  localparam int unsigned AW = bitSize + 1;
  localparam logic [AW-1:0] NA  = AW'(N);
  localparam logic [AW-1:0] ONE = AW'(1);

  // Offset select; row stride N is a constant so no multiplier is needed.
  always_comb begin
    o_addr_c = i_center_addr;
    case (i_idx)
      P1:      o_addr_c = i_center_addr;
      P2:      o_addr_c = i_center_addr - NA;
      P3:      o_addr_c = i_center_addr - NA + ONE;
      P4:      o_addr_c = i_center_addr + ONE;
      P5:      o_addr_c = i_center_addr + NA + ONE;
      P6:      o_addr_c = i_center_addr + NA;
      P7:      o_addr_c = i_center_addr + NA - ONE;
      P8:      o_addr_c = i_center_addr - ONE;
      P9:      o_addr_c = i_center_addr - NA - ONE;
      default: o_addr_c = i_center_addr;
    endcase
  end

endmodule

// File: rtl/window_reader.sv
// 3x3 neighbourhood reader for an N x N image held in RAM.
// Scans every non-border centre in raster order, fetching the nine
// neighbours one per cycle, then presents the window with a valid/ready
// handshake.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin one scan (sampled in IDLE only)
//   rd_addr/rd_data : RAM read port (data combinational from address)
//   win_valid/ready : window handshake
//   win_pixels      : P1..P9, Pk at [(k-1)*pixelWidth +: pixelWidth]
//   win_center_addr : linear address of P1
//   busy, done      : activity flag, end-of-scan pulse
module window_reader
  import window_reader_pkg::*;
#(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [bitSize:0]          rd_addr,
  input  logic [pixelWidth-1:0]     rd_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [9*pixelWidth-1:0]   win_pixels,
  output logic [bitSize:0]          win_center_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned AW = bitSize + 1;
  localparam int unsigned PW = 9 * pixelWidth;
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] LAST     = AW'(N - 2);
  localparam logic [AW-1:0] FIRST_C  = AW'(N + 1);
  // Stepping from (r, N-2) to (r+1, 1) skips two border pixels.
  localparam logic [AW-1:0] ROW_STEP = AW'(3);

  state_e           r_state, w_nxt_state;
  logic [AW-1:0]    r_row, w_nxt_row;
  logic [AW-1:0]    r_col, w_nxt_col;
  logic [IDX_W-1:0] r_idx, w_nxt_idx;
  logic [AW-1:0]    r_center, w_nxt_center;
  logic [AW-1:0]    r_rd_addr, w_nxt_rd_addr;
  logic [PW-1:0]    r_pixels;
  logic [AW-1:0]    r_win_center;
  logic             r_valid, r_busy, r_done;
  logic             w_nxt_done;
  logic             w_last_ctr;
  logic [AW-1:0]    w_gen_addr;

  assign w_last_ctr = (r_row == LAST) && (r_col == LAST);

  // Address for the cycle ahead is computed from next-state values so
  // rd_addr can be registered.
  window_addr_gen #(
    .N       (N),
    .bitSize (bitSize)
  ) u_addr_gen (
    .i_center_addr (w_nxt_center),
    .i_idx         (w_nxt_idx),
    .o_addr_c      (w_gen_addr)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= ONE;
      r_col        <= ONE;
      r_idx        <= '0;
      r_center     <= '0;
      r_rd_addr    <= '0;
      r_pixels     <= '0;
      r_win_center <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_row     <= w_nxt_row;
      r_col     <= w_nxt_col;
      r_idx     <= w_nxt_idx;
      r_center  <= w_nxt_center;
      r_rd_addr <= w_nxt_rd_addr;
      r_valid   <= (w_nxt_state == S_OUT);
      r_busy    <= (w_nxt_state != S_IDLE);
      r_done    <= w_nxt_done;
      if (r_state == S_FETCH) begin
        for (int unsigned k = 0; k < NBR_CNT; k++) begin
          if (r_idx == IDX_W'(k)) begin
            r_pixels[k*pixelWidth +: pixelWidth] <= rd_data;
          end
        end
        if (r_idx == P9) begin
          r_win_center <= r_center;
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_row    = r_row;
    w_nxt_col    = r_col;
    w_nxt_idx    = r_idx;
    w_nxt_center = r_center;
    w_nxt_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state  = S_FETCH;
          w_nxt_row    = ONE;
          w_nxt_col    = ONE;
          w_nxt_idx    = P1;
          w_nxt_center = FIRST_C;
        end
      end
      S_FETCH: begin
        if (r_idx == P9) begin
          w_nxt_state = S_OUT;
          w_nxt_idx   = P1;
        end else begin
          w_nxt_idx = r_idx + IDX_W'(1);
        end
      end
      S_OUT: begin
        if (win_ready) begin
          w_nxt_idx = P1;
          if (w_last_ctr) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_FETCH;
            if (r_col == LAST) begin
              w_nxt_col    = ONE;
              w_nxt_row    = r_row + ONE;
              w_nxt_center = r_center + ROW_STEP;
            end else begin
              w_nxt_col    = r_col + ONE;
              w_nxt_center = r_center + ONE;
            end
          end
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_done  = 1'b1;
      end
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_rd_addr = (w_nxt_state == S_FETCH) ? w_gen_addr : '0;
  end

  assign rd_addr         = r_rd_addr;
  assign win_valid       = r_valid;
  assign win_pixels      = r_pixels;
  assign win_center_addr = r_win_center;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader with N=8 and ram[a]=a.
module tb_window_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_pixels;
  logic [6:0]  win_center_addr;
  logic        busy;
  logic        done;

  logic [7:0]  ram [128];
  int          n_chk;
  int          n_bad;

  window_reader #(.N(8), .bitSize(6), .pixelWidth(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .win_pixels      (win_pixels),
    .win_center_addr (win_center_addr),
    .busy            (busy),
    .done            (done)
  );

  assign rd_data = ram[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected window for centre c with N=8: {P9,...,P1}.
  function automatic logic [71:0] model(input int c);
    return {8'(c - 9), 8'(c - 1), 8'(c + 7), 8'(c + 8),
            8'(c + 9), 8'(c + 1), 8'(c - 7), 8'(c - 8), 8'(c)};
  endfunction

  // One full scan; stall holds win_ready low 5 cycles on window 2,
  // noise pulses start while busy.
  task automatic scan(input bit stall, input bit noise);
    int cyc, nwin, stall_left, done_cyc, exp_c, exp_row, exp_col, exp_t;
    bit pend_acc, prev_valid, fin;
    logic [71:0] held_pix;
    logic [6:0]  held_c;
    cyc = 0; nwin = 0; stall_left = 0; done_cyc = -1;
    exp_c = 9; exp_row = 1; exp_col = 1;
    pend_acc = 0; prev_valid = 0; fin = 0;
    held_pix = '0; held_c = '0;
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 72'(busy), 72'd1);
    chk("rd_addr_first", 72'(rd_addr), 72'd9);
    while (!fin && cyc < 1000) begin
      if (pend_acc) begin
        chk("valid_drop", 72'(win_valid), 72'd0);
        pend_acc = 0;
        nwin++;
        if (exp_col == 6) begin exp_col = 1; exp_row++; end
        else exp_col++;
        exp_c = exp_row * 8 + exp_col;
      end
      if (win_valid && !prev_valid) begin
        chk("center", 72'(win_center_addr), 72'(exp_c));
        chk("pixels", win_pixels, model(exp_c));
        if (nwin == 0) chk("w0_pixels", win_pixels, 72'h00_08_10_11_12_0A_02_01_09);
        if (nwin == 35) chk("w35_pixels", win_pixels, 72'h2D_35_3D_3E_3F_37_2F_2E_36);
        exp_t = 10 * nwin + 9 + ((stall && nwin > 2) ? 5 : 0);
        chk("valid_time", 72'(cyc), 72'(exp_t));
        chk("rd_addr_out", 72'(rd_addr), 72'd0);
        held_pix = win_pixels;
        held_c   = win_center_addr;
        if (stall && nwin == 2) begin
          stall_left = 5;
          win_ready  = 1'b0;
        end
      end else if (stall_left > 0) begin
        chk("stall_valid", 72'(win_valid), 72'd1);
        chk("stall_pixels", win_pixels, held_pix);
        chk("stall_center", 72'(win_center_addr), 72'(held_c));
        stall_left--;
        if (stall_left == 0) win_ready = 1'b1;
      end
      if (win_valid && win_ready) pend_acc = 1;
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        else chk("done_width", 72'(cyc), 72'(done_cyc));
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_low", 72'(done), 72'd0);
        chk("busy_idle", 72'(busy), 72'd0);
        fin = 1;
      end
      start = (noise && busy && (cyc % 7 == 3)) ? 1'b1 : 1'b0;
      prev_valid = win_valid;
      if (!fin) begin
        @(posedge clk); cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("windows", 72'(nwin), 72'd36);
    chk("done_cycle", 72'(done_cyc), 72'(361 + (stall ? 5 : 0)));
  endtask

  // Reset during the 4th FETCH cycle of the third window.
  task automatic reset_mid_scan();
    int saw_done;
    saw_done = 0;
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (23) @(negedge clk);
    chk("rd_addr_p4_w2", 72'(rd_addr), 72'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 72'(win_valid), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_rd_addr", 72'(rd_addr), 72'd0);
    chk("rst_pixels", win_pixels, 72'd0);
    chk("rst_center", 72'(win_center_addr), 72'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || win_valid) saw_done++;
    end
    chk("no_activity_after_rst", 72'(saw_done), 72'd0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    for (int i = 0; i < 128; i++) ram[i] = 8'(i);
    rst_n = 1'b0; start = 1'b0; win_ready = 1'b0;
    #1;
    chk("reset_valid", 72'(win_valid), 72'd0);
    chk("reset_busy", 72'(busy), 72'd0);
    chk("reset_done", 72'(done), 72'd0);
    chk("reset_rd_addr", 72'(rd_addr), 72'd0);
    chk("reset_pixels", win_pixels, 72'd0);
    chk("reset_center", 72'(win_center_addr), 72'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rd_addr", 72'(rd_addr), 72'd0);
    scan(1'b0, 1'b0);
    scan(1'b1, 1'b0);
    scan(1'b0, 1'b1);
    reset_mid_scan();
    scan(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/window_reader.md
WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 Parameters SHALL be: N, 8, image side length in pixels (N >= 3); bitSize, 6, address MSB index (address width bitSize+1, 2^(bitSize+1) >= N*N); pixelWidth, 8, bits per pixel.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port start, input, 1, begin one full-image scan; sampled only in IDLE.
REQ-005 Port rd_addr, output, bitSize+1, read address to the image RAM dual read port.
REQ-006 Port rd_data, input, pixelWidth, RAM dual read data; combinational from rd_addr, valid the same cycle.
REQ-007 Port win_valid, output, 1, 3x3 window available on win_pixels.
REQ-008 Port win_ready, input, 1, consumer accepts the window.
REQ-009 Port win_pixels, output, 9*pixelWidth, neighbourhood P1..P9; Pk at bits [(k-1)*pixelWidth +: pixelWidth].
REQ-010 Port win_center_addr, output, bitSize+1, linear address of P1 (centre).
REQ-011 Port busy, output, 1, high in any state other than IDLE.
REQ-012 Port done, output, 1, single-cycle pulse after the last window is accepted.

Function
REQ-013 States SHALL be IDLE, FETCH, OUT, DONE.
REQ-014 IDLE: start=1 at an edge SHALL load centre row=1, col=1, fetch index=0, and enter FETCH; otherwise stay.
REQ-015 Centres SHALL be visited in raster order, rows 1..N-2, cols 1..N-2; border pixels are never centres.
REQ-016 FETCH SHALL last exactly 9 cycles, driving one neighbour address per cycle in order P1 centre, P2 N, P3 NE, P4 E, P5 SE, P6 S, P7 SW, P8 W, P9 NW, and capturing rd_data into Pk at the end of that cycle.
REQ-017 Neighbour address SHALL be centre + offset, with offsets 0, -N, -N+1, +1, +N+1, +N, +N-1, -1, -N-1, computed modulo 2^(bitSize+1); no multiplier on the per-cycle path.
REQ-018 After the 9th capture the block SHALL enter OUT with win_valid=1; first win_valid occurs 9 cycles after the start edge.
REQ-019 In OUT, win_pixels and win_center_addr SHALL be stable while win_valid=1 and win_ready=0.
REQ-020 A handshake (win_valid and win_ready both high at an edge) SHALL advance the centre: col+1, wrapping to col=1, row+1 after col=N-2; the block then re-enters FETCH with win_valid=0.
REQ-021 A handshake on centre (N-2,N-2) SHALL enter DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-022 Minimum period SHALL be 10 cycles per window (9 FETCH + 1 OUT) with win_ready held high; total (N-2)^2 windows per scan.
REQ-023 start SHALL be ignored while busy=1; win_ready SHALL be ignored outside OUT.
REQ-024 rd_addr SHALL be 0 in IDLE, OUT, and DONE.
REQ-025 The block SHALL never write the RAM.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, row=col=1, fetch index=0, and set win_valid=0, done=0, busy=0, rd_addr=0, win_pixels=0, win_center_addr=0.
REQ-027 Reset mid-scan SHALL abandon the scan without a done pulse; a new start is required after release.

Structure
REQ-028 A shared package SHALL hold the state enum, the neighbour-index constants P1..P9, and the neighbour-count constant (9).
REQ-029 One sub-module, window_addr_gen, SHALL map (centre address, fetch index) to rd_addr combinationally; everything else SHALL reside in window_reader.

Verification
REQ-030 N=8, ram[a]=a, win_ready=1, start pulse -> win_valid 9 cycles later, win_center_addr=9, P1..P9 = 9,1,2,10,18,17,16,8,0.
REQ-031 Same setup, full scan -> 36 windows in raster order, last centre 54 with P1..P9 = 54,46,47,55,63,62,61,53,45; done is a single pulse 361 cycles after the start edge.
REQ-032 win_ready held 0 for 5 cycles in OUT -> win_valid stays 1, win_pixels/win_center_addr unchanged, no advance; accepted on the first edge with win_ready=1.
REQ-033 start re-pulsed during FETCH and OUT -> no effect; window sequence and count unchanged.
REQ-034 rst_n pulsed low during the 4th FETCH cycle of window 3 -> all outputs 0 immediately, no done; a new start rescans from centre 9.
